// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge front end:
// FSM states, AHB transfer encodings and the peripheral address map.
package bridge_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned RESP_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ENABLE
  } state_t;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [RESP_W-1:0]  HRESP_OKAY    = 2'b00;

  // Peripheral windows, 64 MiB each
  localparam logic [31:0] PSEL0_BASE  = 32'h8000_0000;
  localparam logic [31:0] PSEL0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] PSEL1_BASE  = 32'h8400_0000;
  localparam logic [31:0] PSEL1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] PSEL2_BASE  = 32'h8800_0000;
  localparam logic [31:0] PSEL2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [SEL_W-1:0] PSEL_NONE = 3'b000;
  localparam logic [SEL_W-1:0] PSEL_0    = 3'b001;
  localparam logic [SEL_W-1:0] PSEL_1    = 3'b010;
  localparam logic [SEL_W-1:0] PSEL_2    = 3'b100;

endpackage

// File: rtl/apb_bridge_controller_if.sv
// AHB-lite slave side plus APB master side of the bridge.
// Pready is only present when APB_PREADY_EN is defined.
interface apb_bridge_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
`ifdef APB_PREADY_EN
  logic              Pready;
`endif
  logic              Pwrite;
  logic              Penable;
  logic [2:0]        Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic [1:0]        Hresp;

  // Bridge side
  modport slave (
`ifdef APB_PREADY_EN
    input  Pready,
`endif
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );

  // AHB master / APB slave environment side
  modport master (
`ifdef APB_PREADY_EN
    output Pready,
`endif
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational AHB address to one-hot APB peripheral select.
module apb_addr_decode
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic [SEL_W-1:0]  pselx,
  output logic              valid
);

  always_comb begin
    pselx = PSEL_NONE;
    if (haddr >= ADDR_W'(PSEL0_BASE) && haddr <= ADDR_W'(PSEL0_LIMIT))
      pselx = PSEL_0;
    else if (haddr >= ADDR_W'(PSEL1_BASE) && haddr <= ADDR_W'(PSEL1_LIMIT))
      pselx = PSEL_1;
    else if (haddr >= ADDR_W'(PSEL2_BASE) && haddr <= ADDR_W'(PSEL2_LIMIT))
      pselx = PSEL_2;
    valid = |pselx;
  end

endmodule

// File: rtl/apb_bridge_controller.sv
// AHB-lite to APB bridge controller: one transfer at a time, SETUP/ENABLE sequencing.
// Define APB_PREADY_EN to let the APB slave stretch ENABLE with Pready.
module apb_bridge_controller
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                    Hclk,
  input logic                    Hreset,
  apb_bridge_controller_if.slave bus
);

  state_t            state;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_valid;
  logic              accept_c;
  logic              apb_done_c;

  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              hreadyout_q;
  logic [RESP_W-1:0] hresp_q;

  apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .haddr (bus.Haddr),
    .pselx (dec_sel),
    .valid (dec_valid)
  );

  assign accept_c = bus.Hreadyin && dec_valid &&
                    (bus.Htrans == HTRANS_NONSEQ || bus.Htrans == HTRANS_SEQ);

`ifdef APB_PREADY_EN
  assign apb_done_c = bus.Pready;
`else
  assign apb_done_c = 1'b1;
`endif

  // Transfer sequencer; every output is a flop updated here
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state       <= ST_IDLE;
      sel_q       <= PSEL_NONE;
      pselx_q     <= PSEL_NONE;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      hresp_q <= HRESP_OKAY;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            paddr_q     <= bus.Haddr;
            pwrite_q    <= bus.Hwrite;
            sel_q       <= dec_sel;
            hreadyout_q <= 1'b0;
            // Writes wait one cycle for the AHB data phase
            if (bus.Hwrite) begin
              state <= ST_WWAIT;
            end else begin
              pselx_q <= dec_sel;
              state   <= ST_SETUP;
            end
          end
        end
        ST_WWAIT: begin
          pwdata_q <= bus.Hwdata;
          pselx_q  <= sel_q;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ENABLE;
        end
        ST_ENABLE: begin
          if (apb_done_c) begin
            penable_q   <= 1'b0;
            pselx_q     <= PSEL_NONE;
            hreadyout_q <= 1'b1;
            if (!pwrite_q) hrdata_q <= bus.Prdata;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Hrdata    = hrdata_q;
  assign bus.Hreadyout = hreadyout_q;
  assign bus.Hresp     = hresp_q;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Randomized bench for apb_bridge_controller against a transaction-level model.
// Honours APB_PREADY_EN (random ENABLE stretching) when defined.
module tb_apb_bridge_controller;
  import bridge_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic Hclk = 1'b0;
  logic Hreset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model of what the bridge should be presenting while idle
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  logic        m_pwrite;

  apb_bridge_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_bridge_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address map from the window rule: 64 MiB slots starting at 0x8000_0000, three of them
  function automatic logic [2:0] model_decode(input logic [31:0] a);
    logic [31:0] slot;
    if (a < 32'h8000_0000) return 3'b000;
    slot = (a - 32'h8000_0000) >> 26;
    if (slot > 32'd2) return 3'b000;
    return 3'(1 << slot);
  endfunction

  task automatic next_cycle();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive_junk();
    bus.Hreadyin = 1'($urandom);
    bus.Htrans   = 2'($urandom);
    bus.Haddr    = $urandom;
    bus.Hwrite   = 1'($urandom);
    bus.Hwdata   = $urandom;
    bus.Prdata   = $urandom;
`ifdef APB_PREADY_EN
    bus.Pready   = 1'b0;
`endif
  endtask

  task automatic check_idle(input string tag);
    @(negedge Hclk);
    check({tag, ".hreadyout"}, 64'(bus.Hreadyout), 64'(1));
    check({tag, ".pselx"},     64'(bus.Pselx),     64'(0));
    check({tag, ".penable"},   64'(bus.Penable),   64'(0));
    check({tag, ".paddr"},     64'(bus.Paddr),     64'(m_paddr));
    check({tag, ".pwrite"},    64'(bus.Pwrite),    64'(m_pwrite));
    check({tag, ".pwdata"},    64'(bus.Pwdata),    64'(m_pwdata));
    check({tag, ".hrdata"},    64'(bus.Hrdata),    64'(m_rdata));
    check({tag, ".hresp"},     64'(bus.Hresp),     64'(0));
  endtask

  task automatic check_busy(input string tag, input logic [2:0] sel, input logic pen);
    @(negedge Hclk);
    check({tag, ".hreadyout"}, 64'(bus.Hreadyout), 64'(0));
    check({tag, ".pselx"},     64'(bus.Pselx),     64'(sel));
    check({tag, ".penable"},   64'(bus.Penable),   64'(pen));
    check({tag, ".hrdata"},    64'(bus.Hrdata),    64'(m_rdata));
    check({tag, ".hresp"},     64'(bus.Hresp),     64'(0));
    if (sel != 3'b000) begin
      check({tag, ".paddr"},  64'(bus.Paddr),  64'(m_paddr));
      check({tag, ".pwrite"}, 64'(bus.Pwrite), 64'(m_pwrite));
      check({tag, ".pwdata"}, 64'(bus.Pwdata), 64'(m_pwdata));
    end
  endtask

  task automatic idle_cycle();
    drive_junk();
    bus.Htrans = HTRANS_IDLE;
    check_idle("idle");
    next_cycle();
  endtask

  // One AHB transfer offered in the current cycle, followed through to completion
  task automatic run_xfer(input logic w, input logic [31:0] addr, input logic [1:0] trans,
                          input logic rdy, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits);
    logic [2:0] sel;
    logic       acc;
    sel = model_decode(addr);
    acc = rdy && (trans == 2'b10 || trans == 2'b11) && (sel != 3'b000);
    drive_junk();
    bus.Hreadyin = rdy;
    bus.Htrans   = trans;
    bus.Haddr    = addr;
    bus.Hwrite   = w;
    check_idle("offer");
    next_cycle();
    if (!acc) return;
    if (w) begin
      drive_junk();
      bus.Hwdata = wd;
      check_busy("wwait", 3'b000, 1'b0);
      next_cycle();
    end
    m_paddr  = addr;
    m_pwrite = w;
    if (w) m_pwdata = wd;
    drive_junk();
    check_busy("setup", sel, 1'b0);
    next_cycle();
    for (int i = 0; i <= waits; i++) begin
      drive_junk();
      if (i == waits) bus.Prdata = rd;
`ifdef APB_PREADY_EN
      bus.Pready = (i == waits);
`endif
      check_busy("enable", sel, 1'b1);
      next_cycle();
    end
    if (!w) m_rdata = rd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000 + ($urandom & 32'h03FF_FFFF);
      1:       return 32'h8400_0000 + ($urandom & 32'h03FF_FFFF);
      2:       return 32'h8800_0000 + ($urandom & 32'h03FF_FFFF);
      3:       return 32'h7C00_0000 + ($urandom & 32'h1FFF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_paddr  = '0;
    m_pwdata = '0;
    m_rdata  = '0;
    m_pwrite = 1'b0;
    Hreset   = 1'b1;
    drive_junk();
    @(posedge Hclk);
    #1;
    next_cycle();
    Hreset = 1'b0;
    idle_cycle();

    // Directed cases
    run_xfer(1'b1, 32'h8000_0010, HTRANS_NONSEQ, 1'b1, 32'hDEAD_BEEF, 32'h0, 0);
    run_xfer(1'b0, 32'h8800_0004, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h0000_00A5, 0);
    run_xfer(1'b0, 32'h9000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h1111_1111, 0);
    idle_cycle();
    run_xfer(1'b1, 32'h8000_0020, HTRANS_IDLE, 1'b1, 32'h1234_5678, 32'h0, 0);
    idle_cycle();
    run_xfer(1'b1, 32'h8400_0020, HTRANS_BUSY, 1'b1, 32'h1234_5678, 32'h0, 0);
    idle_cycle();
    run_xfer(1'b0, 32'h8400_0020, HTRANS_SEQ, 1'b0, 32'h0, 32'h2222_2222, 0);
    idle_cycle();
    run_xfer(1'b0, 32'h83FF_FFFF, HTRANS_SEQ, 1'b1, 32'h0, 32'h0BAD_F00D, 0);
    run_xfer(1'b1, 32'h8BFF_FFFC, HTRANS_SEQ, 1'b1, 32'hCAFE_0001, 32'h0, 0);
    run_xfer(1'b0, 32'h8C00_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h3333_3333, 0);
    idle_cycle();
    run_xfer(1'b0, 32'h7FFF_FFFF, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h4444_4444, 0);
    idle_cycle();
`ifdef APB_PREADY_EN
    run_xfer(1'b0, 32'h8400_0100, HTRANS_NONSEQ, 1'b1, 32'h0, 32'h5A5A_5A5A, 3);
    run_xfer(1'b1, 32'h8800_0100, HTRANS_NONSEQ, 1'b1, 32'hA5A5_A5A5, 32'h0, 3);
`endif

    // Reset during SETUP of a read aborts the transfer
    drive_junk();
    bus.Hreadyin = 1'b1;
    bus.Htrans   = HTRANS_NONSEQ;
    bus.Haddr    = 32'h8400_0000;
    bus.Hwrite   = 1'b0;
    check_idle("rst_offer");
    next_cycle();
    m_paddr  = 32'h8400_0000;
    m_pwrite = 1'b0;
    drive_junk();
    Hreset = 1'b1;
    check_busy("rst_setup", 3'b010, 1'b0);
    next_cycle();
    Hreset   = 1'b0;
    m_paddr  = '0;
    m_pwdata = '0;
    m_rdata  = '0;
    m_pwrite = 1'b0;
    drive_junk();
    bus.Htrans = HTRANS_IDLE;
    check_idle("post_rst");
    next_cycle();
    idle_cycle();

    // Random traffic, back-to-back and with idle gaps
    for (int n = 0; n < 300; n++) begin
      int waits;
`ifdef APB_PREADY_EN
      waits = int'($urandom_range(0, 3));
`else
      waits = 0;
`endif
      run_xfer(1'($urandom), rand_addr(), 2'($urandom), ($urandom_range(0, 7) != 0),
               $urandom, $urandom, waits);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
